// File: rtl/trg_lvl_if.sv
// Sample stream tap feeding trg_lvl: signed ADC sample plus valid, no backpressure.
interface trg_lvl_if #(
    parameter int DW = 14
);
    logic [DW-1:0] dat;
    logic          vld;

    modport master (output dat, output vld);
    modport slave  (input  dat, input  vld);
endinterface

// File: rtl/trg_lvl.sv
// Level/edge trigger with hysteresis arming and programmable holdoff.
// Optional trigger pulse counter on sts_cnt when TRG_LVL_CNT_EN is defined.
module trg_lvl #(
    parameter int DW = 14,
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          rstn,
    trg_lvl_if.slave      sti,
    input  logic          ctl_rst,
    input  logic          cfg_en,
    input  logic          cfg_edg,
    input  logic [DW-1:0] cfg_lvl,
    input  logic [DW-1:0] cfg_hst,
    input  logic [CW-1:0] cfg_hld,
    output logic          trg,
    output logic          sts_arm,
    output logic          sts_hld
`ifdef TRG_LVL_CNT_EN
    ,
    output logic [31:0]   sts_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          clr;

    // One extra bit keeps lvl +/- hst exact over the full signed range.
    logic signed [DW:0] dat_x;
    logic signed [DW:0] lvl_x;
    logic signed [DW:0] hst_x;
    logic signed [DW:0] arm_lo;
    logic signed [DW:0] arm_hi;
    logic               arm_hit;
    logic               fire_hit;
    logic               fire;

    always_comb begin
        dat_x    = {sti.dat[DW-1], sti.dat};
        lvl_x    = {cfg_lvl[DW-1], cfg_lvl};
        hst_x    = {1'b0, cfg_hst};
        arm_lo   = lvl_x - hst_x;
        arm_hi   = lvl_x + hst_x;
        arm_hit  = cfg_edg ? (dat_x > arm_hi) : (dat_x < arm_lo);
        fire_hit = cfg_edg ? (dat_x <= lvl_x) : (dat_x >= lvl_x);
        fire     = (state == ARMED) && sti.vld && fire_hit;
        clr      = !rstn || ctl_rst || !cfg_en;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
            cnt   <= '0;
            trg   <= 1'b0;
        end else begin
            trg <= 1'b0;
            case (state)
                IDLE: begin
                    if (sti.vld && arm_hit)
                        state <= ARMED;
                end
                ARMED: begin
                    if (fire) begin
                        state <= HOLD;
                        cnt   <= cfg_hld;
                        trg   <= 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == '0)
                        state <= IDLE;
                    else
                        cnt <= cnt - CW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign sts_arm = (state == ARMED);
    assign sts_hld = (state == HOLD);

`ifdef TRG_LVL_CNT_EN
    always_ff @(posedge clk) begin
        if (clr)
            sts_cnt <= '0;
        else if (fire)
            sts_cnt <= sts_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_trg_lvl.sv
// Directed-vector bench for trg_lvl; inputs change on negedge, outputs checked 1 ns after posedge.
module tb_trg_lvl;

    localparam int DW = 14;
    localparam int CW = 32;

    logic          clk;
    logic          rstn;
    logic          ctl_rst;
    logic          cfg_en;
    logic          cfg_edg;
    logic [DW-1:0] cfg_lvl;
    logic [DW-1:0] cfg_hst;
    logic [CW-1:0] cfg_hld;
    logic          trg;
    logic          sts_arm;
    logic          sts_hld;
`ifdef TRG_LVL_CNT_EN
    logic [31:0]   sts_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    trg_lvl_if #(.DW(DW)) sti ();

    trg_lvl #(.DW(DW), .CW(CW)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .sti     (sti),
        .ctl_rst (ctl_rst),
        .cfg_en  (cfg_en),
        .cfg_edg (cfg_edg),
        .cfg_lvl (cfg_lvl),
        .cfg_hst (cfg_hst),
        .cfg_hld (cfg_hld),
        .trg     (trg),
        .sts_arm (sts_arm),
        .sts_hld (sts_hld)
`ifdef TRG_LVL_CNT_EN
        ,
        .sts_cnt (sts_cnt)
`endif
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic send(input int d, input logic v);
        @(negedge clk);
        sti.dat = DW'(d);
        sti.vld = v;
        @(posedge clk);
        #1;
    endtask

    task automatic soft_rst();
        @(negedge clk);
        sti.vld = 1'b0;
        ctl_rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        ctl_rst = 1'b0;
    endtask

    task automatic set_cfg(input logic edg, input int lvl, input int hst, input int hld);
        @(negedge clk);
        cfg_edg = edg;
        cfg_lvl = DW'(lvl);
        cfg_hst = DW'(hst);
        cfg_hld = CW'(hld);
    endtask

    int ntrg;
    int tidx;
    int nhld;
    int narm;
    int nf;
    int fires [8];

    initial begin
        rstn    = 1'b0;
        ctl_rst = 1'b0;
        cfg_en  = 1'b1;
        cfg_edg = 1'b0;
        cfg_lvl = '0;
        cfg_hst = '0;
        cfg_hld = '0;
        sti.dat = '0;
        sti.vld = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_trg", 32'(trg), 0);
        check("rst_arm", 32'(sts_arm), 0);
        check("rst_hld", 32'(sts_hld), 0);
        @(negedge clk);
        rstn = 1'b1;

        // Rising ramp 0..2000 step 50, lvl=1000 hst=100 hld=10
        set_cfg(1'b0, 1000, 100, 10);
        ntrg = 0; tidx = -1; nhld = 0;
        for (int i = 0; i <= 40; i++) begin
            send(i * 50, 1'b1);
            if (i == 0)  check("ris_arm0", 32'(sts_arm), 1);
            if (i == 19) check("ris_arm19", 32'(sts_arm), 1);
            if (trg) begin ntrg++; tidx = i; end
            if (sts_hld) nhld++;
        end
        check("ris_ntrg", 32'(ntrg), 1);
        check("ris_tidx", 32'(tidx), 20);
        check("ris_nhld", 32'(nhld), 11);
        check("ris_end", {30'd0, sts_arm, sts_hld}, 0);

        // Falling ramp 0..-1000, lvl=-500 hst=0; invalid samples first must not arm
        soft_rst();
        set_cfg(1'b1, -500, 0, 3);
        send(0, 1'b0);
        send(0, 1'b0);
        check("fal_novld", 32'(sts_arm), 0);
        ntrg = 0; tidx = -1;
        for (int i = 0; i <= 20; i++) begin
            send(-50 * i, 1'b1);
            if (i == 0) check("fal_arm0", 32'(sts_arm), 1);
            if (trg) begin ntrg++; tidx = i; end
        end
        check("fal_ntrg", 32'(ntrg), 1);
        check("fal_tidx", 32'(tidx), 10);

        // Hysteresis rejection
        soft_rst();
        set_cfg(1'b0, 0, 200, 2);
        ntrg = 0; narm = 0;
        for (int i = 0; i < 20; i++) begin
            send((i % 2 == 0) ? -150 : 150, 1'b1);
            if (trg) ntrg++;
            if (sts_arm) narm++;
        end
        check("hst_ntrg", 32'(ntrg), 0);
        check("hst_narm", 32'(narm), 0);
        send(-250, 1'b1);
        check("hst_arm", 32'(sts_arm), 1);
        send(150, 1'b1);
        check("hst_trg", 32'(trg), 1);

        // Holdoff: rising crossing every 20 samples, hld=50 -> every third
        soft_rst();
        set_cfg(1'b0, 0, 10, 50);
        nf = 0;
        for (int i = 0; i < 160; i++) begin
            send(((i / 10) % 2 == 0) ? -100 : 100, 1'b1);
            if (trg) begin
                if (nf < 8) fires[nf] = i;
                nf++;
            end
        end
        check("hld50_n", 32'(nf), 3);
        if (nf >= 3) begin
            check("hld50_f0", 32'(fires[0]), 10);
            check("hld50_f1", 32'(fires[1]), 70);
            check("hld50_f2", 32'(fires[2]), 130);
        end
        soft_rst();
        set_cfg(1'b0, 0, 10, 0);
        nf = 0;
        for (int i = 0; i < 160; i++) begin
            send(((i / 10) % 2 == 0) ? -100 : 100, 1'b1);
            if (trg) nf++;
        end
        check("hld0_n", 32'(nf), 8);

        // Reset and disable priority
        soft_rst();
        set_cfg(1'b0, 0, 10, 20);
        send(-100, 1'b1);
        check("rd_arm", 32'(sts_arm), 1);
        @(negedge clk);
        sti.dat = DW'(100);
        ctl_rst = 1'b1;
        @(posedge clk);
        #1;
        check("rd_crst", {29'd0, trg, sts_arm, sts_hld}, 0);
        @(negedge clk);
        ctl_rst = 1'b0;
        send(-100, 1'b1);
        send(100, 1'b1);
        check("rd_fire", {29'd0, trg, sts_arm, sts_hld}, 5);
        send(100, 1'b1);
        send(100, 1'b1);
        check("rd_inhld", 32'(sts_hld), 1);
        @(negedge clk);
        cfg_en = 1'b0;
        @(posedge clk);
        #1;
        check("rd_dis", {29'd0, trg, sts_arm, sts_hld}, 0);
        @(negedge clk);
        cfg_en = 1'b1;
        send(100, 1'b1);
        check("rd_noarm", 32'(sts_arm), 0);
        send(-100, 1'b1);
        send(100, 1'b1);
        send(100, 1'b1);
        check("rd_hld2", 32'(sts_hld), 1);
        @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check("rd_rstn", {29'd0, trg, sts_arm, sts_hld}, 0);
        @(negedge clk);
        rstn = 1'b1;

        // Extremes: lvl=8191 hst=8191 -> arm_lo=0
        set_cfg(1'b0, 8191, 8191, 0);
        send(0, 1'b1);
        check("ext_noarm0", 32'(sts_arm), 0);
        ntrg = 0;
        for (int k = 0; k < 3; k++) begin
            send(-1, 1'b1);
            if (k == 0) check("ext_arm", 32'(sts_arm), 1);
            if (k == 0) begin
                send(8190, 1'b1);
                check("ext_8190", 32'(trg), 0);
            end
            send(8191, 1'b1);
            if (trg) ntrg++;
            send(0, 1'b1);
        end
        check("ext_ntrg", 32'(ntrg), 3);
`ifdef TRG_LVL_CNT_EN
        check("cnt_3", sts_cnt, 3);
        soft_rst();
        check("cnt_clr", sts_cnt, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/trg_lvl.md
Name: trg_lvl

Overview:
- Analog level/edge trigger source that turns a sampled ADC stream into single-cycle trigger pulses.
- Sits directly upstream of the trigger counter `ctrg`; its `trg` output drives `ctrg.trg` (one bit of the TN-wide trigger vector).
- Provides edge polarity, hysteresis-based arming and a programmable holdoff.
- Configuration comes from static registers owned by the surrounding system-bus register block. This block has no bus port.

Parameters:
- DW, 14, ADC sample width (signed two's complement).
- CW, 32, holdoff counter width.

Ports:
- clk  in  1  system clock, 125 MHz.
- rstn  in  1  reset. Synchronous, active-low. Sampled on the posedge of clk.
- sti_dat  in  DW  signed ADC sample.
- sti_vld  in  1  sample valid. This is a tap with no ready: a sample is consumed whenever sti_vld=1.
- ctl_rst  in  1  software reset pulse. Same effect as rstn.
- cfg_en  in  1  enable. When 0, the FSM is forced to IDLE and trg is held at 0.
- cfg_edg  in  1  edge select: 0 = rising, 1 = falling.
- cfg_lvl  in  DW  signed trigger level.
- cfg_hst  in  DW  unsigned hysteresis, 0 to 2^(DW-1)-1.
- cfg_hld  in  CW  holdoff length in clk cycles.
- trg  out  1  trigger pulse, one clk wide.
- sts_arm  out  1  high while state is ARMED.
- sts_hld  out  1  high while state is HOLD.

Behaviour:
- Reset (rstn=0 or ctl_rst=1 at a clk edge):
  - state=IDLE, holdoff counter=0.
  - trg, sts_arm, sts_hld all =0.
  - Reset has priority over every other input, including mid-holdoff and while ARMED.
- Threshold arithmetic:
  - Thresholds are computed in DW+1 signed bits: arm_lo = lvl − hst, arm_hi = lvl + hst.
  - No wrap and no saturation is needed, so a comparison never aliases.
- States:
  - IDLE: wait to arm.
    - Rising: a valid sample with sti_dat < arm_lo moves to ARMED.
    - Falling: a valid sample with sti_dat > arm_hi moves to ARMED.
  - ARMED: wait for the crossing.
    - Rising: a valid sample with sti_dat >= lvl fires.
    - Falling: a valid sample with sti_dat <= lvl fires.
    - On fire: trg=1 on the next clk (1-cycle latency from the accepted sample), state goes to HOLD, counter loads cfg_hld.
  - HOLD: the counter decrements by 1 every clk, independent of sti_vld, and samples are ignored.
    - When the counter is 0, the next clk moves to IDLE.
    - cfg_hld=0 means exactly one HOLD cycle.
- Fire timing:
  - The arm and fire conditions are disjoint for any hst >= 0, so a fire always needs at least two accepted samples.
  - Minimum spacing between trg pulses is cfg_hld+3 clk cycles.
- sti_vld=0: the state is unchanged in IDLE and ARMED, with no compare performed.
- cfg_en=0: synchronous force to IDLE and the counter is cleared. Re-enabling restarts from IDLE, so no stale arm is possible.
- Config changes: cfg_lvl, cfg_hst and cfg_edg changes take effect on the next accepted sample, and the current state is kept. cfg_hld is sampled only at the load into HOLD.
- Output registration: all outputs are registered. sts_arm and sts_hld are decoded from the registered state.

Optional Feature:
- Macro: TRG_LVL_CNT_EN.
- Defined:
  - Adds output port sts_cnt [32], a count of trg pulses.
  - Increments on the same clk that trg=1.
  - Wraps from 2^32−1 to 0.
  - Cleared by rstn, ctl_rst or cfg_en=0.
- Undefined: the port and the counter logic are absent. All other behaviour is identical.

Test Plan:
- Rising edge, lvl=1000, hst=100, hld=10, stream 0→2000 in steps of 50 with vld=1:
  - ARMED after the first sample below 900.
  - Exactly one trg, one clk after sample 1000.
  - sts_hld high for 11 clk, then IDLE.
- Falling edge, lvl=−500, hst=0, ramp 0→−1000:
  - Arm at the first sample >−500 (sample 0).
  - trg one clk after sample −500.
- Hysteresis rejection, rising, lvl=0, hst=200, noise alternating −150/+150:
  - No trg, because the block never arms.
  - Add one −250 sample: armed, then trg on the following +150.
- Holdoff, sine crossing 0 every 20 clk, hld=50, rising, lvl=0, hst=10:
  - trg on every third crossing only.
  - With hld=0: trg on every rising crossing.
- Reset and disable:
  - Assert ctl_rst while ARMED, then cfg_en=0 during HOLD; both go to IDLE next clk with all outputs 0.
  - rstn=0 mid-HOLD gives the same result.
- Extremes, DW=14, lvl=8191, hst=8191, rising:
  - arm_lo = 0, with no overflow.
  - Sample −1 arms; sample 8191 fires.
  - With TRG_LVL_CNT_EN: after 3 fires sts_cnt=3, and 0 after ctl_rst.
